// File: rtl/top_level.sv
// Single-cycle 8-bit load/store processor running a fixed ROM program:
// mem[2] = mem[0] ^ mem[1], mem[5] = mem[3] & mem[4], then HALT (done held until reset).

module dmem #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  localparam int DEPTH = 1 << AW;

  // No reset on purpose: preloaded contents must survive a processor reset.
  logic [DW-1:0] core [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) core[addr] <= wdata;
  end

  assign rdata = core[addr];
endmodule

module top_level #(
  parameter int DW = 8,
  parameter int IW = 9,
  parameter int AW = 8
) (
  input  logic clk,
  input  logic reset,
  output logic done
);
  localparam logic [2:0] OP_LI   = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  logic [AW-1:0] pc;
  logic [IW-1:0] instr;
  logic [2:0]    op;
  logic [2:0]    ra;
  logic [2:0]    rb;
  logic [DW-1:0] regs [0:7];
  logic [DW-1:0] a_val;
  logic [DW-1:0] b_val;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] mem_rdata;
  logic          reg_we;
  logic          mem_we;
  logic          halt;

  // Instruction ROM; every unlisted address decodes as HALT.
  always_comb begin
    instr = {OP_HALT, 3'd0, 3'd0};
    case (pc)
      8'd0:    instr = {OP_LI,  3'd1, 3'd0};
      8'd1:    instr = {OP_LI,  3'd2, 3'd1};
      8'd2:    instr = {OP_LW,  3'd3, 3'd1};
      8'd3:    instr = {OP_LW,  3'd4, 3'd2};
      8'd4:    instr = {OP_XOR, 3'd3, 3'd4};
      8'd5:    instr = {OP_LI,  3'd5, 3'd2};
      8'd6:    instr = {OP_SW,  3'd3, 3'd5};
      8'd7:    instr = {OP_LI,  3'd1, 3'd3};
      8'd8:    instr = {OP_LI,  3'd2, 3'd4};
      8'd9:    instr = {OP_LW,  3'd3, 3'd1};
      8'd10:   instr = {OP_LW,  3'd4, 3'd2};
      8'd11:   instr = {OP_AND, 3'd3, 3'd4};
      8'd12:   instr = {OP_LI,  3'd5, 3'd5};
      8'd13:   instr = {OP_SW,  3'd3, 3'd5};
      default: instr = {OP_HALT, 3'd0, 3'd0};
    endcase
  end

  assign op    = instr[8:6];
  assign ra    = instr[5:3];
  assign rb    = instr[2:0];
  assign a_val = regs[ra];
  assign b_val = regs[rb];

  // Decode + ALU: selects the register write-back value and the enables.
  always_comb begin
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    halt    = 1'b0;
    wb_data = '0;
    case (op)
      OP_LI:   begin reg_we = 1'b1; wb_data = {{(DW-3){1'b0}}, rb}; end
      OP_LW:   begin reg_we = 1'b1; wb_data = mem_rdata; end
      OP_SW:   mem_we = 1'b1;
      OP_XOR:  begin reg_we = 1'b1; wb_data = a_val ^ b_val; end
      OP_AND:  begin reg_we = 1'b1; wb_data = a_val & b_val; end
      OP_ADD:  begin reg_we = 1'b1; wb_data = a_val + b_val; end
      OP_SUB:  begin reg_we = 1'b1; wb_data = a_val - b_val; end
      default: halt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc   <= '0;
      done <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (halt) done <= 1'b1;
      else      pc   <= pc + 1'b1;
      if (reg_we) regs[ra] <= wb_data;
    end
  end

  // Reset wins over a store issued in the same cycle.
  dmem #(.DW(DW), .AW(AW)) dm1 (
    .clk   (clk),
    .we    (mem_we & ~reset),
    .addr  (b_val),
    .wdata (a_val),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: random memory images, program effect predicted from
// the two-line program semantics, whole-memory comparison after each run.

module tb_top_level;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic done;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] model_mem [0:255];
  logic [7:0] exp_q[$];

  top_level dut (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic poke(input int addr, input logic [7:0] v);
    model_mem[addr] = v;
    dut.dm1.core[addr] = v;
  endtask

  task automatic preload_random();
    for (int i = 0; i < 256; i++) poke(i, 8'($urandom_range(0, 255)));
  endtask

  // Called at a negedge; leaves reset asserted.
  task automatic pulse_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
      check("done_in_reset", done, 0);
    end
  endtask

  // Releases reset and waits (bounded) for done; done must first appear after edge 15.
  task automatic run_program(input string tag);
    int edges;
    bit seen;
    reset = 1'b0;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_edge"}, edges, 15);
    model_mem[2] = model_mem[0] ^ model_mem[1];
    model_mem[5] = model_mem[3] & model_mem[4];
  endtask

  // scoreboard: whole data memory against the model image
  task automatic check_memory(input string tag);
    logic [7:0] e;
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(model_mem[i]);
    for (int i = 0; i < 256; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_mem[%0d]", tag, i), dut.dm1.core[i], e);
    end
  endtask

  initial begin
    @(negedge clk);
    pulse_reset(2);

    // basic run with fixed operands
    preload_random();
    poke(0, 8'hF0); poke(1, 8'hCC); poke(3, 8'hC3); poke(4, 8'h55); poke(254, 8'h0F);
    run_program("t1");
    check("t1_mem2", dut.dm1.core[2], 8'h3C);
    check("t1_mem5", dut.dm1.core[5], 8'h41);
    check("t1_mem254", dut.dm1.core[254], 8'h0F);
    check_memory("t1");
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      check("t1_done_hold", done, 1);
      check("t1_mem2_hold", dut.dm1.core[2], 8'h3C);
      check("t1_mem5_hold", dut.dm1.core[5], 8'h41);
    end

    // all-zero / all-ones operands
    pulse_reset(1);
    preload_random();
    poke(0, 8'h00); poke(1, 8'h00); poke(3, 8'hFF); poke(4, 8'hFF);
    run_program("t3");
    check("t3_mem2", dut.dm1.core[2], 8'h00);
    check("t3_mem5", dut.dm1.core[5], 8'hFF);
    check_memory("t3");

    // reset at edge 5, before any store
    pulse_reset(1);
    preload_random();
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t4_done_mid_reset", done, 0);
    check_memory("t4_mid");
    run_program("t4");
    check_memory("t4");

    // change operands after halt, then rerun
    poke(0, 8'h01); poke(1, 8'h02);
    pulse_reset(1);
    run_program("t5");
    check("t5_mem2", dut.dm1.core[2], 8'h03);
    check_memory("t5");

    // long reset from halted state: no writes at all
    preload_random();
    pulse_reset(10);
    check_memory("t6");

    // random images
    for (int k = 0; k < 4; k++) begin
      pulse_reset(1 + $urandom_range(0, 2));
      preload_random();
      run_program($sformatf("r%0d", k));
      check_memory($sformatf("r%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
